// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : knn_pkg
// Purpose : Shared defaults, FSM state encoding and the K-clamp helper for
//           the knn_query_driver front end.
// Contents: KNN_* default sizes, knn_state_t, knn_clamp_k().
// Revision: 1.0  initial release
// ============================================================================
package knn_pkg;

  localparam int unsigned KNN_DATA_WIDTH   = 8;
  localparam int unsigned KNN_NUM_FEATURES = 2;
  localparam int unsigned KNN_NUM_TRAINING = 50;
  localparam int unsigned KNN_K_DEFAULT    = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESULT  = 3'd4
  } knn_state_t;

  // K of zero means "use the default"; K above the training-set size is
  // meaningless for the classifier, so it is pinned to the set size.
  function automatic int unsigned knn_clamp_k(input int unsigned k,
                                              input int unsigned k_default,
                                              input int unsigned num_training);
    if (k == 0) begin
      return k_default;
    end else if (k > num_training) begin
      return num_training;
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : knn_watchdog
// Purpose : Loadable up-counter with clear/enable that flags when it holds
//           LIMIT-1. Used for the WAIT timeout and the RECOVER pulse length.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           clr           - force count to 0 (highest priority)
//           load/load_val - load an arbitrary start value
//           en            - count up (saturates at LIMIT-1)
//           expire        - count == LIMIT-1
// Revision: 1.0  initial release
// ============================================================================
module knn_watchdog #(
  parameter  int unsigned LIMIT = 1000,
  localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expire
);

  localparam logic [CW-1:0] C_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = (count_q == C_LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_query_driver.sv
`default_nettype none
// ============================================================================
// Module  : knn_query_driver
// Purpose : Initiator front end for knn_classifier. Takes one query at a time
//           from a valid/ready stream, clamps K, pulses knn_start, waits for a
//           rising edge of knn_done under a watchdog and returns class, tag and
//           timeout flag on a valid/ready result stream. On timeout the
//           classifier is held in reset for RECOVER_CYCLES cycles.
// Ports   : clk/rst                 - clock, synchronous active-high reset
//           q_valid/q_ready/q_data/q_k          - query stream
//           knn_start/knn_test_data/knn_k_value/knn_rst - classifier controls
//           knn_predicted_class/knn_done        - classifier result
//           r_valid/r_ready/r_class/r_tag/r_timeout - result stream
//           busy                    - FSM not in IDLE
//           last_latency            - start-to-completion cycles of last result
// Options : KNN_DRV_PERF_EN - enables the latency counter behind last_latency
//           (tied to 0 otherwise).
// Revision: 1.0  initial release
// ============================================================================
module knn_query_driver
  import knn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = KNN_DATA_WIDTH,
  parameter int unsigned NUM_FEATURES   = KNN_NUM_FEATURES,
  parameter int unsigned NUM_TRAINING   = KNN_NUM_TRAINING,
  parameter int unsigned K_DEFAULT      = KNN_K_DEFAULT,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               q_valid,
  output logic                               q_ready,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0] q_data,
  input  logic [DATA_WIDTH-1:0]              q_k,
  output logic                               knn_start,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0] knn_test_data,
  output logic [DATA_WIDTH-1:0]              knn_k_value,
  output logic                               knn_rst,
  input  logic                               knn_predicted_class,
  input  logic                               knn_done,
  output logic                               r_valid,
  input  logic                               r_ready,
  output logic                               r_class,
  output logic [TAG_WIDTH-1:0]               r_tag,
  output logic                               r_timeout,
  output logic                               busy,
  output logic [15:0]                        last_latency
);

  localparam int unsigned FW    = DATA_WIDTH * NUM_FEATURES;
  localparam int unsigned TO_CW = $clog2(TIMEOUT_CYCLES + 1);

  knn_state_t           state_q, state_d;
  logic [FW-1:0]        test_data_q, test_data_d;
  logic [DATA_WIDTH-1:0] k_value_q, k_value_d;
  logic [TAG_WIDTH-1:0] tag_cnt_q, tag_cnt_d;
  logic [TAG_WIDTH-1:0] r_tag_q, r_tag_d;
  logic                 r_class_q, r_class_d;
  logic                 r_timeout_q, r_timeout_d;
  logic                 done_q;

  logic done_edge;
  logic to_load, to_en, to_expire;
  logic rc_clr, rc_en, rc_expire;

  // Only a fresh 0->1 transition counts as completion, so a done level left
  // high by the previous query cannot complete the new one.
  assign done_edge = knn_done && !done_q;

  assign q_ready       = (state_q == ST_IDLE) && !rst;
  assign knn_start     = (state_q == ST_ISSUE);
  assign knn_rst       = rst || (state_q == ST_RECOVER);
  assign r_valid       = (state_q == ST_RESULT);
  assign busy          = (state_q != ST_IDLE);
  assign knn_test_data = test_data_q;
  assign knn_k_value   = k_value_q;
  assign r_class       = r_class_q;
  assign r_tag         = r_tag_q;
  assign r_timeout     = r_timeout_q;

  // The ISSUE cycle is loaded as count 1 so the ISSUE+WAIT window spans
  // exactly TIMEOUT_CYCLES cycles before RECOVER is entered.
  knn_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (to_load),
    .load_val (TO_CW'(1)),
    .en       (to_en),
    .expire   (to_expire)
  );

  knn_watchdog #(.LIMIT(RECOVER_CYCLES)) u_recover (
    .clk      (clk),
    .rst      (rst),
    .clr      (rc_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (rc_en),
    .expire   (rc_expire)
  );

  always_comb begin
    state_d     = state_q;
    test_data_d = test_data_q;
    k_value_d   = k_value_q;
    tag_cnt_d   = tag_cnt_q;
    r_tag_d     = r_tag_q;
    r_class_d   = r_class_q;
    r_timeout_d = r_timeout_q;
    to_load     = 1'b0;
    to_en       = 1'b0;
    rc_clr      = 1'b1;
    rc_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (q_valid) begin
          test_data_d = q_data;
          k_value_d   = DATA_WIDTH'(knn_clamp_k(32'(q_k), K_DEFAULT, NUM_TRAINING));
          r_tag_d     = tag_cnt_q;
          tag_cnt_d   = tag_cnt_q + 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        to_en = 1'b1;
        // A completion in the expiry cycle still delivers a real result.
        if (done_edge) begin
          r_class_d   = knn_predicted_class;
          r_timeout_d = 1'b0;
          state_d     = ST_RESULT;
        end else if (to_expire) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        rc_clr = 1'b0;
        rc_en  = 1'b1;
        if (rc_expire) begin
          r_class_d   = 1'b0;
          r_timeout_d = 1'b1;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (r_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      test_data_q <= '0;
      k_value_q   <= DATA_WIDTH'(K_DEFAULT);
      tag_cnt_q   <= '0;
      r_tag_q     <= '0;
      r_class_q   <= 1'b0;
      r_timeout_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      test_data_q <= test_data_d;
      k_value_q   <= k_value_d;
      tag_cnt_q   <= tag_cnt_d;
      r_tag_q     <= r_tag_d;
      r_class_q   <= r_class_d;
      r_timeout_q <= r_timeout_d;
      done_q      <= knn_done;
    end
  end

`ifdef KNN_DRV_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic [15:0] last_latency_q, last_latency_d;

  // perf_cnt_d already includes the current cycle, so sampling it on the
  // transition into RESULT gives the start..completion count inclusive
  // (RECOVER cycles are not counted).
  always_comb begin
    perf_cnt_d     = perf_cnt_q;
    last_latency_d = last_latency_q;
    if (state_q == ST_ISSUE) begin
      perf_cnt_d = 16'd1;
    end else if ((state_q == ST_WAIT) && (perf_cnt_q != 16'hFFFF)) begin
      perf_cnt_d = perf_cnt_q + 16'd1;
    end
    if ((state_q != ST_RESULT) && (state_d == ST_RESULT)) begin
      last_latency_d = perf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q     <= '0;
      last_latency_q <= '0;
    end else begin
      perf_cnt_q     <= perf_cnt_d;
      last_latency_q <= last_latency_d;
`ifndef SYNTHESIS
      if ((state_q != ST_RESULT) && (state_d == ST_RESULT)) begin
        $display("knn_query_driver: tag %0d latency %0d", r_tag_d, last_latency_d);
      end
`endif
    end
  end

  assign last_latency = last_latency_q;
`else
  assign last_latency = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_knn_query_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_knn_query_driver
// Purpose : Self-checking bench for knn_query_driver with a behavioural
//           classifier model (programmable delay, stale done, never-done).
// Options : KNN_DRV_PERF_EN - also checks last_latency.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_knn_query_driver;

  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned RECOVER = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [15:0] q_data;
  logic [7:0]  q_k;
  logic        knn_start;
  logic [15:0] knn_test_data;
  logic [7:0]  knn_k_value;
  logic        knn_rst;
  logic        knn_predicted_class = 1'b0;
  logic        knn_done = 1'b0;
  logic        r_valid;
  logic        r_ready;
  logic        r_class;
  logic [7:0]  r_tag;
  logic        r_timeout;
  logic        busy;
  logic [15:0] last_latency;

  int n_vec = 0;
  int n_err = 0;
  int tag_model = 0;

  // classifier model controls
  int m_delay = 20;
  bit m_class = 1'b0;
  bit m_never = 1'b0;
  bit m_stale = 1'b0;
  bit armed   = 1'b0;
  int mcnt    = 0;

  always #5 clk = ~clk;

  knn_query_driver #(
    .DATA_WIDTH     (8),
    .NUM_FEATURES   (2),
    .NUM_TRAINING   (50),
    .K_DEFAULT      (3),
    .TAG_WIDTH      (8),
    .TIMEOUT_CYCLES (TIMEOUT),
    .RECOVER_CYCLES (RECOVER)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .q_valid             (q_valid),
    .q_ready             (q_ready),
    .q_data              (q_data),
    .q_k                 (q_k),
    .knn_start           (knn_start),
    .knn_test_data       (knn_test_data),
    .knn_k_value         (knn_k_value),
    .knn_rst             (knn_rst),
    .knn_predicted_class (knn_predicted_class),
    .knn_done            (knn_done),
    .r_valid             (r_valid),
    .r_ready             (r_ready),
    .r_class             (r_class),
    .r_tag               (r_tag),
    .r_timeout           (r_timeout),
    .busy                (busy),
    .last_latency        (last_latency)
  );

  // Classifier model: done is a level that rises m_delay cycles after the
  // start cycle and stays high until the next start. In stale mode the old
  // level survives the start and drops briefly before the real rise.
  always @(posedge clk) begin
    if (knn_rst) begin
      knn_done <= 1'b0;
      armed    <= 1'b0;
      mcnt     <= 0;
    end else if (knn_start) begin
      armed <= 1'b1;
      mcnt  <= 1;
      if (!m_stale) knn_done <= 1'b0;
      knn_predicted_class <= ~m_class;
    end else if (armed) begin
      mcnt <= mcnt + 1;
      if (m_stale && mcnt == 3) knn_done <= 1'b0;
      if (!m_never && mcnt == m_delay - 1) begin
        knn_done            <= 1'b1;
        knn_predicted_class <= m_class;
        armed               <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_query(input logic [15:0] data, input logic [7:0] k, input int delay,
                          input bit cls, input bit never, input bit stale, input int bp);
    int         waited;
    int         first_rst;
    int         rst_cnt;
    int         val_cyc;
    int         starts;
    bit         stable;
    bit         qr_bad;
    logic [7:0] exp_k;
    int         exp_tag;
    bit         exp_cls;

    exp_k     = (k == 8'd0) ? 8'd3 : ((k > 8'd50) ? 8'd50 : k);
    exp_tag   = tag_model;
    tag_model = (tag_model + 1) % 256;
    exp_cls   = never ? 1'b0 : cls;
    m_delay   = delay;
    m_class   = cls;
    m_never   = never;
    m_stale   = stale;

    waited = 0;
    while (!q_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!q_ready) begin
      check("q_ready_wait", 0, 1);
      return;
    end
    q_data  = data;
    q_k     = k;
    q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    q_data  = 16'($urandom);
    q_k     = 8'($urandom);
    check("start_pulse", knn_start, 1);
    check("k_value", knn_k_value, exp_k);
    check("test_data", knn_test_data, data);

    first_rst = -1;
    rst_cnt   = 0;
    val_cyc   = -1;
    starts    = 0;
    stable    = 1'b1;
    qr_bad    = 1'b0;
    for (int cyc = 1; cyc <= 1500; cyc++) begin
      @(negedge clk);
      if (knn_start) starts++;
      if (knn_rst) begin
        if (first_rst < 0) first_rst = cyc;
        rst_cnt++;
      end
      if (knn_test_data !== data || knn_k_value !== exp_k) stable = 1'b0;
      if (q_ready) qr_bad = 1'b1;
      if (r_valid) begin
        val_cyc = cyc;
        break;
      end
    end
    if (val_cyc < 0) begin
      check("r_valid_seen", 0, 1);
      return;
    end
    check("no_extra_start", starts, 0);
    check("inputs_stable", stable, 1);
    check("q_ready_busy", qr_bad, 0);
    if (never) begin
      check("rst_start", first_rst, TIMEOUT);
      check("rst_len", rst_cnt, RECOVER);
      check("latency", val_cyc, TIMEOUT + RECOVER);
    end else begin
      check("rst_none", rst_cnt, 0);
      check("latency", val_cyc, delay + 1);
    end
    check("r_class", r_class, exp_cls);
    check("r_tag", r_tag, exp_tag);
    check("r_timeout", r_timeout, never);
`ifdef KNN_DRV_PERF_EN
    check("last_latency", last_latency, never ? TIMEOUT : delay + 1);
`endif
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", r_valid, 1);
      check("bp_class", r_class, exp_cls);
      check("bp_tag", r_tag, exp_tag);
      check("bp_q_ready", q_ready, 0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("released", r_valid, 0);
    check("idle_ready", q_ready, 1);
  endtask

  initial begin
    bit st;
    int d;
    rst     = 1'b1;
    q_valid = 1'b0;
    q_data  = '0;
    q_k     = '0;
    r_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q_ready", q_ready, 0);
    check("rst_start", knn_start, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_k", knn_k_value, 3);
    check("rst_data", knn_test_data, 0);
    check("rst_tag", r_tag, 0);
    check("rst_timeout", r_timeout, 0);
    check("rst_class", r_class, 0);
    check("rst_knn_rst", knn_rst, 1);
    check("rst_latency", last_latency, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", q_ready, 1);
    check("post_rst_knn_rst", knn_rst, 0);

    // first query, class 0 after 20 cycles
    do_query(16'h0408, 8'd3, 20, 1'b0, 1'b0, 1'b0, 0);
    // K clamp
    do_query(16'h1122, 8'd0,   10, 1'b1, 1'b0, 1'b0, 0);
    do_query(16'h3344, 8'd100, 10, 1'b0, 1'b0, 1'b0, 0);
    do_query(16'h5566, 8'd7,   10, 1'b1, 1'b0, 1'b0, 0);
    // backpressure
    do_query(16'h7788, 8'd5, 12, 1'b1, 1'b0, 1'b0, 5);
    // stale done level carried over from the previous query
    do_query(16'h99AA, 8'd9, 15, 1'b1, 1'b0, 1'b1, 0);
    // timeout then a normal query
    do_query(16'hBBCC, 8'd4, 0, 1'b1, 1'b1, 1'b0, 2);
    do_query(16'hDDEE, 8'd6, 9, 1'b1, 1'b0, 1'b0, 0);

    // randomized queries
    for (int i = 0; i < 20; i++) begin
      st = 1'($urandom_range(0, 1));
      d  = st ? int'($urandom_range(8, 30)) : int'($urandom_range(2, 30));
      do_query(16'($urandom), 8'($urandom), d, 1'($urandom), 1'b0, st,
               int'($urandom_range(0, 3)));
    end

    // reset in the middle of WAIT
    m_never = 1'b1;
    m_stale = 1'b0;
    q_data  = 16'hCAFE;
    q_k     = 8'd5;
    q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_knn_rst", knn_rst, 1);
    check("mid_rst_q_ready", q_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_r_valid", r_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_ready", q_ready, 1);
    check("after_rst_busy", busy, 0);
    check("after_rst_r_valid", r_valid, 0);
    check("after_rst_k", knn_k_value, 3);
    tag_model = 0;

    // 300 back-to-back queries: tags 0..255 then 0..43
    for (int i = 0; i < 300; i++) begin
      do_query(16'($urandom), 8'($urandom), 2, 1'($urandom), 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
